// File: rtl/rv_pkg.sv
// rv_pkg: shared funct3 encodings, NOP word, MEM-stage state type and alignment helper.
package rv_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic {IDLE, ACCESS} mem_state_t;

    // Any funct3 that is not a byte or half access behaves as a word access.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (f3 == F3_B || f3 == F3_BU) ? 1'b0 :
               (f3 == F3_H || f3 == F3_HU) ? a[0] : |a;
    endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane replication/strobes, load byte/half extraction with sign or zero extension.
module mem_align
    import rv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);
    logic       byte_op, half_op;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        byte_op    = funct3 == F3_B || funct3 == F3_BU;
        half_op    = funct3 == F3_H || funct3 == F3_HU;
        b          = rdata[{addr, 3'b000} +: 8];
        h          = addr[1] ? rdata[31:16] : rdata[15:0];
        wstrb      = byte_op ? 4'b0001 << addr : half_op ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata      = byte_op ? {4{store_data[7:0]}} : half_op ? {2{store_data[15:0]}} : store_data;
        load_data  = funct3 == F3_B  ? {{24{b[7]}}, b} :
                     funct3 == F3_BU ? {24'd0, b} :
                     funct3 == F3_H  ? {{16{h[15]}}, h} :
                     funct3 == F3_HU ? {16'd0, h} : rdata;
        misaligned = is_misaligned(funct3, addr);
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I MEM stage with EX/MEM and MEM/WB registers and a req/ack data-memory port.
// Define MEM_ACCESS_TIMEOUT_EN to abandon accesses after TIMEOUT_CYCLES and pulse bus_error.
module mem_stage
    import rv_pkg::*;
`ifdef MEM_ACCESS_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_reg,
    input  logic [31:0] ex_mem_instruction,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_instruction,
    output logic        misalign
`ifdef MEM_ACCESS_TIMEOUT_EN
    ,
    output logic        bus_error
`endif
);
    mem_state_t  state;
    logic [31:0] em_alu, em_rs2, em_instr;
    logic [4:0]  em_rd;
    logic        em_rw, em_mr, em_mw, em_mreg;
    logic [3:0]  strb;
    logic [31:0] wdat, load_data;
    logic        mis_a, timeout, access, done, ex_access;

    mem_align u_align (
        .funct3    (em_instr[14:12]),
        .addr      (em_alu[1:0]),
        .store_data(em_rs2),
        .rdata     (dmem_rdata),
        .wstrb     (strb),
        .wdata     (wdat),
        .load_data (load_data),
        .misaligned(mis_a)
    );

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CW = TIMEOUT_CYCLES > 255 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt;
    assign timeout   = state == ACCESS && !dmem_ack && cnt == CW'(TIMEOUT_CYCLES);
    assign bus_error = timeout;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else      cnt <= mem_stall ? cnt + 1'b1 : '0;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        access     = state == ACCESS && !timeout;
        dmem_req   = access;
        dmem_we    = access && em_mw;
        dmem_addr  = {em_alu[31:2], 2'b00};
        dmem_wdata = wdat;
        dmem_wstrb = dmem_we ? strb : 4'b0000;
        mem_stall  = access && !dmem_ack;
        misalign   = (em_mr || em_mw) && mis_a;
        done       = state == ACCESS ? access && dmem_ack : !misalign;
        ex_access  = (ex_mem_read || ex_mem_write) &&
                     !is_misaligned(ex_mem_instruction[14:12], ex_alu_result[1:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            em_alu         <= '0;
            em_rs2         <= '0;
            em_instr       <= '0;
            em_rd          <= '0;
            em_rw          <= 1'b0;
            em_mr          <= 1'b0;
            em_mw          <= 1'b0;
            em_mreg        <= 1'b0;
            wb_data        <= '0;
            wb_rd          <= '0;
            wb_reg_write   <= 1'b0;
            wb_instruction <= '0;
        end else begin
            if (!mem_stall) begin
                state    <= ex_access ? ACCESS : IDLE;
                em_alu   <= ex_alu_result;
                em_rs2   <= ex_rs2_data;
                em_instr <= ex_mem_instruction;
                em_rd    <= ex_rd;
                em_rw    <= ex_reg_write;
                em_mr    <= ex_mem_read;
                em_mw    <= ex_mem_write;
                em_mreg  <= ex_mem_reg;
            end
            // Stalled, timed-out and misaligned ops all retire as a NOP bubble.
            wb_data        <= done ? (em_mreg ? load_data : em_alu) : '0;
            wb_rd          <= done ? em_rd : '0;
            wb_reg_write   <= done && em_rw;
            wb_instruction <= done ? em_instr : NOP;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven vectors plus stall/back-to-back/reset sequences with a WB scoreboard.
module tb_mem_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] ex_alu_result = '0, ex_rs2_data = '0, ex_mem_instruction = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_mem_reg = 1'b0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        mem_stall, dmem_req, dmem_we, wb_reg_write, misalign;
    logic [31:0] dmem_addr, dmem_wdata, wb_data, wb_instruction;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  wb_rd;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_reg(ex_mem_reg), .ex_mem_instruction(ex_mem_instruction),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_instruction(wb_instruction), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, rs2;
        logic [4:0]  rd;
        logic        rw, mr, mw, mreg;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic        req, we, mis;
        logic [31:0] addr, wdata;
        logic [3:0]  wstrb;
        logic [31:0] wbd;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
        logic [31:0] ins;
    } wb_t;

    vec_t tv[$];
    wb_t  sb[$];
    int   n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] alu, rs2, input logic [4:0] rd,
                                input logic rw, mr, mw, mreg, input logic [2:0] f3,
                                input logic [31:0] rdata, input logic req, we, mis,
                                input logic [31:0] addr, wdata, input logic [3:0] wstrb,
                                input logic [31:0] wbd);
        vec_t v;
        v = '{alu, rs2, rd, rw, mr, mw, mreg, f3, rdata, req, we, mis, addr, wdata, wstrb, wbd};
        return v;
    endfunction

    function automatic logic [31:0] ins(input logic [2:0] f3, input logic [4:0] rd);
        return {17'd0, f3, rd, 7'h03};
    endfunction

    task automatic drive(input logic [31:0] alu, rs2, input logic [4:0] rd,
                         input logic rw, mr, mw, mreg, input logic [31:0] instr);
        ex_alu_result = alu; ex_rs2_data = rs2; ex_rd = rd; ex_reg_write = rw;
        ex_mem_read = mr; ex_mem_write = mw; ex_mem_reg = mreg; ex_mem_instruction = instr;
    endtask

    task automatic bubble();
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h13);
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] d, input logic [31:0] instr);
        wb_t e;
        e = '{rd, d, instr};
        sb.push_back(e);
    endtask

    // Scoreboard: every WB write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wb_reg_write) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h expected no write", wb_rd, wb_data);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_data", wb_data, e.d);
                chk("wb_instruction", wb_instruction, e.ins);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        logic [31:0] instr;
        instr = ins(v.f3, v.rd);
        drive(v.alu, v.rs2, v.rd, v.rw, v.mr, v.mw, v.mreg, instr);
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk("req", 32'(dmem_req), 32'(v.req));
        chk("misalign", 32'(misalign), 32'(v.mis));
        if (v.req) begin
            chk("addr", dmem_addr, v.addr);
            chk("we", 32'(dmem_we), 32'(v.we));
            if (v.we) begin
                chk("wstrb", 32'(dmem_wstrb), 32'(v.wstrb));
                chk("wdata", dmem_wdata, v.wdata);
            end
        end
        dmem_ack = v.req;
        dmem_rdata = v.rdata;
        #1 chk("stall", 32'(mem_stall), 32'd0);
        if (v.rw && !v.mis) push(v.rd, v.wbd, instr);
        bubble();
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("req_after", 32'(dmem_req), 32'd0);
        chk("misalign_after", 32'(misalign), 32'd0);
    endtask

    initial begin
        //            alu           rs2           rd  rw mr mw mg f3      rdata         rq we ms addr          wdata         wstrb    wbd
        tv.push_back(mk(32'h1234,     32'h0,        5,  1, 0, 0, 0, 3'b000, 32'h0,        0, 0, 0, 32'h0,       32'h0,        4'b0000, 32'h1234));
        tv.push_back(mk(32'h1003,     32'h0,        6,  1, 1, 0, 1, 3'b000, 32'h80FFFFFF, 1, 0, 0, 32'h1000,    32'h0,        4'b0000, 32'hFFFFFF80));
        tv.push_back(mk(32'h1003,     32'h0,        6,  1, 1, 0, 1, 3'b100, 32'h80FFFFFF, 1, 0, 0, 32'h1000,    32'h0,        4'b0000, 32'h00000080));
        tv.push_back(mk(32'h1002,     32'h0,        7,  1, 1, 0, 1, 3'b001, 32'h80FF1234, 1, 0, 0, 32'h1000,    32'h0,        4'b0000, 32'hFFFF80FF));
        tv.push_back(mk(32'h1000,     32'h0,        8,  1, 1, 0, 1, 3'b101, 32'h80FF8001, 1, 0, 0, 32'h1000,    32'h0,        4'b0000, 32'h00008001));
        tv.push_back(mk(32'h1004,     32'h0,        9,  1, 1, 0, 1, 3'b010, 32'hDEADBEEF, 1, 0, 0, 32'h1004,    32'h0,        4'b0000, 32'hDEADBEEF));
        tv.push_back(mk(32'h1001,     32'h0,        10, 1, 1, 0, 1, 3'b000, 32'h12345678, 1, 0, 0, 32'h1000,    32'h0,        4'b0000, 32'h00000056));
        tv.push_back(mk(32'h2002,     32'hABCD1234, 0,  0, 0, 1, 0, 3'b001, 32'h0,        1, 1, 0, 32'h2000,    32'h12341234, 4'b1100, 32'h0));
        tv.push_back(mk(32'h2001,     32'h000000A5, 0,  0, 0, 1, 0, 3'b000, 32'h0,        1, 1, 0, 32'h2000,    32'hA5A5A5A5, 4'b0010, 32'h0));
        tv.push_back(mk(32'h2008,     32'hCAFEF00D, 0,  0, 0, 1, 0, 3'b010, 32'h0,        1, 1, 0, 32'h2008,    32'hCAFEF00D, 4'b1111, 32'h0));
        tv.push_back(mk(32'h3001,     32'h0,        9,  1, 1, 0, 1, 3'b010, 32'h0,        0, 0, 1, 32'h0,       32'h0,        4'b0000, 32'h0));
        tv.push_back(mk(32'h2003,     32'h1111,     0,  0, 0, 1, 0, 3'b001, 32'h0,        0, 0, 1, 32'h0,       32'h0,        4'b0000, 32'h0));
        tv.push_back(mk(32'h3002,     32'h0,        11, 1, 1, 0, 1, 3'b001, 32'h7FFF0000, 1, 0, 0, 32'h3000,    32'h0,        4'b0000, 32'h00007FFF));
        tv.push_back(mk(32'h3004,     32'h0,        12, 1, 1, 0, 1, 3'b011, 32'h11223344, 1, 0, 0, 32'h3004,    32'h0,        4'b0000, 32'h11223344));
        tv.push_back(mk(32'h3006,     32'h0,        13, 1, 1, 0, 1, 3'b110, 32'h0,        0, 0, 1, 32'h0,       32'h0,        4'b0000, 32'h0));
        tv.push_back(mk(32'h4000,     32'h00000055, 0,  0, 1, 1, 0, 3'b010, 32'h0,        1, 1, 0, 32'h4000,    32'h00000055, 4'b1111, 32'h0));
        tv.push_back(mk(32'h2003,     32'h1234567F, 0,  0, 0, 1, 0, 3'b000, 32'h0,        1, 1, 0, 32'h2000,    32'h7F7F7F7F, 4'b1000, 32'h0));
        tv.push_back(mk(32'h1001,     32'h0,        14, 1, 1, 0, 1, 3'b101, 32'h0,        0, 0, 1, 32'h0,       32'h0,        4'b0000, 32'h0));
        tv.push_back(mk(32'hFFFFFFFF, 32'h0,        31, 1, 0, 0, 0, 3'b010, 32'h0,        0, 0, 0, 32'h0,       32'h0,        4'b0000, 32'hFFFFFFFF));

        #2 rst = 1'b0;
        #1;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_wb_write", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_instr", wb_instruction, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        bubble();
        @(posedge clk); #1;

        foreach (tv[i]) run_vec(tv[i]);

        // Load with three wait cycles, then an ADD that follows on the ack cycle.
        drive(32'h1003, '0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, ins(3'b000, 5'd7));
        dmem_rdata = 32'h80FFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("lb_wait_stall", 32'(mem_stall), 32'd1);
            chk("lb_wait_req", 32'(dmem_req), 32'd1);
            if (i > 0) chk("lb_wait_wb_nop", wb_instruction, 32'h13);
        end
        dmem_ack = 1'b1;
        #1 chk("lb_ack_stall", 32'(mem_stall), 32'd0);
        push(5'd7, 32'hFFFFFF80, ins(3'b000, 5'd7));
        drive(32'h77, '0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000433);
        push(5'd8, 32'h77, 32'h00000433);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("add_after_lb_stall", 32'(mem_stall), 32'd0);
        bubble();
        @(posedge clk); #1;

        // Back-to-back zero-wait SW then LW.
        drive(32'h5000, 32'h01020304, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ins(3'b010, 5'd0));
        @(posedge clk); #1;
        chk("b2b_sw_req", 32'(dmem_req), 32'd1);
        chk("b2b_sw_we", 32'(dmem_we), 32'd1);
        chk("b2b_sw_addr", dmem_addr, 32'h5000);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        #1 chk("b2b_sw_stall", 32'(mem_stall), 32'd0);
        drive(32'h5004, '0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, ins(3'b010, 5'd10));
        push(5'd10, 32'h0BADF00D, ins(3'b010, 5'd10));
        @(posedge clk); #1;
        chk("b2b_lw_req", 32'(dmem_req), 32'd1);
        chk("b2b_lw_we", 32'(dmem_we), 32'd0);
        chk("b2b_lw_addr", dmem_addr, 32'h5004);
        chk("b2b_lw_stall", 32'(mem_stall), 32'd0);
        bubble();
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("b2b_req_drop", 32'(dmem_req), 32'd0);

        // Asynchronous reset in the middle of an outstanding load; a late ack must not write back.
        drive(32'h6000, '0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, ins(3'b010, 5'd11));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_req", 32'(dmem_req), 32'd1);
        chk("mid_stall", 32'(mem_stall), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", 32'(dmem_req), 32'd0);
        chk("arst_stall", 32'(mem_stall), 32'd0);
        chk("arst_wb_instr", wb_instruction, 32'd0);
        chk("arst_wb_rd", 32'(wb_rd), 32'd0);
        bubble();
        @(posedge clk); #1 rst = 1'b1;
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("late_ack_wb_write", 32'(wb_reg_write), 32'd0);
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); #1;

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage RV32I core. Consumes EX results and drives the data-memory bus.
- Holds the EX/MEM and MEM/WB pipeline registers.
- Runs a req/ack handshake with data memory, including byte/half/word alignment and load sign-extension.
- Asserts mem_stall to freeze IF/ID/EX while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for dmem_ack. Used only with the optional feature.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- ex_alu_result  in  32  effective address or ALU result
- ex_rs2_data  in  32  store data
- ex_rd  in  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_reg  in  1 each  EX control signals
- ex_mem_instruction  in  32  instruction word; funct3 = bits [14:12]
- mem_stall  out  1  hold upstream stages and keep the EX outputs stable
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2], 2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables
- dmem_ack  in  1  access complete; rdata is valid on the same cycle
- dmem_rdata  in  32  read word
- wb_data  out  32  load result or ALU result
- wb_rd  out  5  destination register to WB
- wb_reg_write  out  1  write enable to WB
- wb_instruction  out  32  instruction word to WB
- misalign  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset (rst=0, async): all registers cleared; FSM=IDLE; every output = 0 (dmem_req drops immediately). An in-flight access is abandoned. A late ack after reset is ignored because FSM is IDLE.
- EX/MEM register: captures all ex_* inputs on each clock edge where mem_stall=0. Holds while mem_stall=1.
- FSM states:
  - IDLE: EX/MEM holds a non-memory op, a misaligned op, or a bubble.
  - ACCESS: EX/MEM holds an aligned load/store.
  - Transitions are evaluated at each edge from the newly captured EX/MEM contents. ACCESS -> ACCESS is legal on back-to-back memory ops; dmem_req may stay high across the boundary.
- In ACCESS:
  - dmem_req=1; dmem_we=mem_write.
  - dmem_addr, dmem_wdata and dmem_wstrb stay stable until ack.
  - mem_stall = ~dmem_ack (combinational). A zero-wait memory therefore causes no bubble.
- Non-memory op: mem_stall=0; passes to MEM/WB at the next edge, giving 1-cycle stage latency.
- MEM/WB register, every edge:
  - Op completing (IDLE op, or ACCESS with ack): wb_data = mem_reg ? load_data : alu_result; wb_rd, wb_reg_write and wb_instruction taken from EX/MEM.
  - Stalled cycle: captures a bubble (wb_reg_write=0, wb_rd=0, wb_data=0, wb_instruction=0x00000013).
- Store strobes:
  - SB: wstrb = 0001 << addr[1:0]; wdata = 4 copies of the byte.
  - SH: wstrb = 0011 << (2*addr[1]); wdata = 2 copies of the half.
  - SW: wstrb = 1111.
- Loads: select the byte/half from dmem_rdata using addr[1:0].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: whole word.
- Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0):
  - No bus request; FSM stays IDLE.
  - misalign pulses for the cycle the op sits in EX/MEM.
  - MEM/WB receives a bubble (wb_reg_write=0).
- Both mem_read and mem_write set: illegal; treated as a store.
- Reserved funct3 values: treated as LW/SW.

Optional Feature:
- Macro MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter increments each ACCESS cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop dmem_req, pulse output bus_error (1 bit, reset 0) for one cycle, send a bubble to MEM/WB, deassert mem_stall.
  - The counter clears on every ack or new access.
- Undefined: no counter and no bus_error port; the stage waits indefinitely for ack.

Decomposition:
- Shared package rv_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - NOP encoding 32'h00000013.
  - mem_state_t enum {IDLE, ACCESS}.
- One combinational sub-module, mem_align:
  - Inputs: funct3, addr[1:0], store data, rdata.
  - Outputs: wstrb, wdata, load_data, misaligned.

Test Plan:
- Reset with dmem_req high mid-access -> dmem_req=0 asynchronously; all outputs 0; a later ack causes no WB write.
- ADD (alu_result=0x1234, rd=5), then release -> next cycle wb_data=0x1234, wb_rd=5, wb_reg_write=1, mem_stall never high.
- LB at 0x1003, ack after 3 cycles with rdata=0x80FFFFFF -> mem_stall=1 for 3 cycles with WB bubbles; then wb_data=0xFFFFFF80; LBU gives 0x00000080.
- SH at 0x2002 with rs2=0xABCD1234 -> dmem_addr=0x2000, wstrb=1100, wdata=0x12341234, we=1, wb_reg_write=0.
- LW at 0x3001 -> misalign pulses 1 cycle, dmem_req stays 0, wb_reg_write=0; a following ADD completes normally.
- Back-to-back SW then LW, both with zero-wait ack -> no stall cycles; dmem_req high on 2 consecutive cycles; LW data written on the second.
